// File: rtl/tlc_pkg.sv
// Shared constants and FSM state type for the
// TLC5940 left/right chain scan sequencer.
package tlc_pkg;

  localparam int GS_BITS   = 12;
  localparam int CHANNELS  = 16;
  localparam int LANES     = 6;
  localparam int ROWS      = 8;
  localparam int GS_COUNT  = 4096;
  localparam int SHIFT_LEN = GS_BITS * CHANNELS;

  function automatic int addr_width(
    input int rows,
    input int len
  );
    return $clog2(rows * len);
  endfunction

  localparam int ADDR_W = addr_width(ROWS, SHIFT_LEN);
  localparam int ROW_W  = $clog2(ROWS);
  localparam int BIT_W  = $clog2(SHIFT_LEN);
  localparam int GS_W   = $clog2(2 * GS_COUNT);

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    GS_RUN,
    BLANK,
    LATCH,
    UNBLANK
  } tlc_state_e;

endpackage

// File: rtl/tlc_scan_sequencer_if.sv
// Frame-buffer read port between the scan
// sequencer (master) and the buffer (slave).
interface tlc_scan_sequencer_if
  import tlc_pkg::*;
();

  logic [ADDR_W-1:0]  rd_addr;
  logic               rd_en;
  logic [2*LANES-1:0] rd_data;

  modport master (
    output rd_addr,
    output rd_en,
    input  rd_data
  );

  modport slave (
    input  rd_addr,
    input  rd_en,
    output rd_data
  );

endinterface

// File: rtl/tlc_shift_engine.sv
// Streams one row of grayscale bits from the
// frame buffer into every lane, two cycles per bit.
module tlc_shift_engine
  import tlc_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [ROW_W-1:0] row,
  output logic             done,
  output logic             sclk,
  output logic [LANES-1:0] sin_l,
  output logic [LANES-1:0] sin_r,
  tlc_scan_sequencer_if.master fb
);

  localparam logic [BIT_W-1:0] LAST =
    BIT_W'(SHIFT_LEN - 1);
  localparam logic [BIT_W-1:0] LAST_M1 =
    BIT_W'(SHIFT_LEN - 2);

  logic               active;
  logic               pre;
  logic               rd_vld;
  logic [BIT_W-1:0]   bit_idx;
  logic [ADDR_W-1:0]  base;
  logic [ADDR_W-1:0]  row_base;
  logic [2*LANES-1:0] rd_q;
  logic [2*LANES-1:0] fresh;

  assign row_base =
    ADDR_W'(row) * ADDR_W'(SHIFT_LEN);
  // bit 0 arrives during its own phase A; later
  // bits arrive a cycle early and wait in rd_q
  assign fresh = rd_vld ? fb.rd_data : rd_q;
  assign done  = ~active;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      active     <= 1'b0;
      pre        <= 1'b0;
      rd_vld     <= 1'b0;
      bit_idx    <= '0;
      base       <= '0;
      rd_q       <= '0;
      sclk       <= 1'b0;
      sin_l      <= '0;
      sin_r      <= '0;
      fb.rd_en   <= 1'b0;
      fb.rd_addr <= '0;
    end else begin
      rd_vld   <= fb.rd_en;
      fb.rd_en <= 1'b0;
      if (rd_vld) rd_q <= fb.rd_data;
      if (!active) begin
        sclk <= 1'b0;
        if (start) begin
          active     <= 1'b1;
          pre        <= 1'b1;
          bit_idx    <= '0;
          base       <= row_base;
          fb.rd_en   <= 1'b1;
          fb.rd_addr <= row_base;
        end
      end else if (pre) begin
        pre        <= 1'b0;
        fb.rd_en   <= 1'b1;
        fb.rd_addr <= base + ADDR_W'(1);
      end else if (!sclk) begin
        sclk  <= 1'b1;
        sin_l <= fresh[LANES-1:0];
        sin_r <= fresh[2*LANES-1:LANES];
      end else begin
        sclk <= 1'b0;
        if (bit_idx == LAST) begin
          active  <= 1'b0;
          bit_idx <= '0;
        end else begin
          bit_idx <= bit_idx + BIT_W'(1);
          if (bit_idx != LAST_M1) begin
            fb.rd_en   <= 1'b1;
            fb.rd_addr <= base
                        + ADDR_W'(bit_idx)
                        + ADDR_W'(2);
          end
        end
      end
    end
  end

endmodule

// File: rtl/tlc_scan_sequencer.sv
// Row scan FSM for the TLC5940 chains: PWM cycle,
// blank/latch gap, row advance and error capture.
module tlc_scan_sequencer
  import tlc_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  tlc_scan_sequencer_if.master fb,
  output logic             led_sclk,
  output logic [LANES:1]   led_l_sin,
  output logic [LANES:1]   led_r_sin,
  input  logic             led_xerr,
  output logic             led_mode,
  output logic             led_blank,
  output logic             led_xlat,
  output logic             led_gsclk,
  output logic [ROW_W-1:0] row_sel,
  output logic             frame_start,
  output logic             xerr_flag
);

  localparam logic [GS_W-1:0] GS_LAST =
    GS_W'(2 * GS_COUNT - 1);

  tlc_state_e       state;
  tlc_state_e       state_nx;
  logic [GS_W-1:0]  gs_cnt;
  logic [ROW_W-1:0] shift_row;
  logic [ROW_W-1:0] start_row;
  logic             start;
  logic             shift_done;
  logic             xerr_m;
  logic             xerr_s;

  tlc_shift_engine u_shift (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .row     (start_row),
    .done    (shift_done),
    .sclk    (led_sclk),
    .sin_l   (led_l_sin),
    .sin_r   (led_r_sin),
    .fb      (fb)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    start     = 1'b0;
    start_row = shift_row + ROW_W'(1);
    unique case (state)
      IDLE: begin
        if (enable) begin
          start     = 1'b1;
          start_row = '0;
          state_nx  = PRIME;
        end
      end
      PRIME: begin
        if (shift_done) state_nx = BLANK;
      end
      GS_RUN: begin
        if (gs_cnt == GS_LAST) state_nx = BLANK;
      end
      BLANK: begin
        if (shift_done) state_nx = LATCH;
      end
      LATCH: begin
        state_nx = UNBLANK;
      end
      UNBLANK: begin
        if (enable) begin
          start    = 1'b1;
          state_nx = GS_RUN;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      gs_cnt      <= '0;
      led_gsclk   <= 1'b0;
      shift_row   <= '0;
      row_sel     <= '0;
      frame_start <= 1'b0;
      xerr_m      <= 1'b1;
      xerr_s      <= 1'b1;
      xerr_flag   <= 1'b0;
    end else begin
      xerr_m <= led_xerr;
      xerr_s <= xerr_m;
      if (state == GS_RUN && !xerr_s)
        xerr_flag <= 1'b1;
      gs_cnt <= (state == GS_RUN)
              ? gs_cnt + GS_W'(1) : '0;
      // last GS_RUN cycle has gsclk high, so the
      // exit edge is also the final falling edge
      led_gsclk <= (state == GS_RUN) && !led_gsclk;
      if (start) shift_row <= start_row;
      if (state == LATCH) row_sel <= shift_row;
      frame_start <= (state == LATCH)
                  && (shift_row == '0);
    end
  end

  assign led_blank = (state != GS_RUN);
  assign led_xlat  = (state == LATCH);
  assign led_mode  = 1'b0;

endmodule

// File: tb/tb_tlc_scan_sequencer.sv
// Scoreboard bench for tlc_scan_sequencer: frame
// buffer model, bit-stream, PWM and row checks.
`timescale 1ns/1ps
module tb_tlc_scan_sequencer;

  localparam int SLEN   = 192;
  localparam int GS_N   = 4096;
  localparam int PERIOD = 8195;

  logic clk = 1'b0;
  logic reset_n;
  logic enable;
  logic led_xerr;
  logic led_sclk;
  logic [6:1] led_l_sin;
  logic [6:1] led_r_sin;
  logic led_mode;
  logic led_blank;
  logic led_xlat;
  logic led_gsclk;
  logic [2:0] row_sel;
  logic frame_start;
  logic xerr_flag;

  tlc_scan_sequencer_if fb ();

  tlc_scan_sequencer dut (
    .clock       (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .fb          (fb),
    .led_sclk    (led_sclk),
    .led_l_sin   (led_l_sin),
    .led_r_sin   (led_r_sin),
    .led_xerr    (led_xerr),
    .led_mode    (led_mode),
    .led_blank   (led_blank),
    .led_xlat    (led_xlat),
    .led_gsclk   (led_gsclk),
    .row_sel     (row_sel),
    .frame_start (frame_start),
    .xerr_flag   (xerr_flag)
  );

  always #12.5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  logic [11:0] exp_q[$];

  task automatic push_row(input int r);
    for (int k = 0; k < SLEN; k++)
      exp_q.push_back(12'(r * SLEN + k));
  endtask

  // frame buffer: data valid only in the cycle
  // after rd_en, garbage otherwise
  logic        mem_en = 1'b0;
  logic [11:0] mem_dat = '0;
  always @(negedge clk) begin
    if (mem_en) fb.rd_data = mem_dat;
    else        fb.rd_data = 12'($urandom);
    mem_en  = fb.rd_en;
    mem_dat = 12'(fb.rd_addr);
  end

  int   cyc = 0;
  int   bit_no = 0;
  int   xlat_cnt = 0;
  int   xlat_cyc = 0;
  int   frame_cnt = 0;
  int   gs_rises = 0;
  int   exp_row = 0;
  bit   gs_armed = 1'b0;
  bit   first = 1'b1;
  logic sclk_q = 1'b0;
  logic gsclk_q = 1'b0;
  logic xlat_q = 1'b0;
  logic blank_q = 1'b1;

  always @(negedge clk) begin
    logic [11:0] e;
    cyc++;
    if (led_sclk && !sclk_q) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sin", {led_r_sin, led_l_sin}, e);
      end else begin
        check("sin_extra",
              {led_r_sin, led_l_sin}, 'x);
      end
      bit_no++;
    end
    if (led_gsclk && !gsclk_q && !led_blank)
      gs_rises++;
    if (led_xlat && !xlat_q) begin
      xlat_cnt++;
      check("xlat_blank", led_blank, 1);
      check("sb_left", exp_q.size(), 0);
      if (gs_armed) begin
        check("gs_edges", gs_rises, GS_N);
        check("row_period", cyc - xlat_cyc, PERIOD);
      end
      gs_armed = 1'b0;
      gs_rises = 0;
      xlat_cyc = cyc;
    end
    if (!led_xlat && xlat_q) begin
      exp_row = first ? 0 : (exp_row + 1) % 8;
      first   = 1'b0;
      check("row_sel", row_sel, exp_row);
      check("frame_start", frame_start,
            exp_row == 0);
      if (enable) push_row((exp_row + 1) % 8);
      bit_no = 0;
    end
    if (frame_start) frame_cnt++;
    if (!led_blank && blank_q) begin
      gs_armed = 1'b1;
      check("unblank_lat", cyc - xlat_cyc, 2);
    end
    sclk_q  = led_sclk;
    gsclk_q = led_gsclk;
    xlat_q  = led_xlat;
    blank_q = led_blank;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_latch(
    input int n,
    input int budget
  );
    int k = 0;
    while (xlat_cnt < n && k < budget) begin
      step(1);
      k++;
    end
    if (xlat_cnt < n)
      check("tmo_latch", xlat_cnt, n);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_blank"}, led_blank, 1);
    check({tag, "_xlat"}, led_xlat, 0);
    check({tag, "_sclk"}, led_sclk, 0);
    check({tag, "_gsclk"}, led_gsclk, 0);
    check({tag, "_row"}, row_sel, 0);
    check({tag, "_mode"}, led_mode, 0);
    check({tag, "_fs"}, frame_start, 0);
    check({tag, "_xerr"}, xerr_flag, 0);
    check({tag, "_rden"}, fb.rd_en, 0);
    check({tag, "_sin"},
          {led_r_sin, led_l_sin}, 0);
  endtask

  initial begin
    int k;
    reset_n  = 1'b0;
    enable   = 1'b0;
    led_xerr = 1'b1;
    step(4);
    check_idle("rst");
    reset_n = 1'b1;
    step(100);
    check_idle("idle");

    // startup; error pulse while blanked in PRIME
    first  = 1'b1;
    push_row(0);
    bit_no = 0;
    enable = 1'b1;
    step(20);
    led_xerr = 1'b0;
    step(3);
    led_xerr = 1'b1;
    wait_latch(1, 1000);
    k = 0;
    while (led_blank && k < 20) begin
      step(1);
      k++;
    end
    check("gs_started", led_blank, 0);
    step(100);
    check("xerr_blanked", xerr_flag, 0);

    // error pulse during GS_RUN
    led_xerr = 1'b0;
    step(3);
    check("xerr_set", xerr_flag, 1);
    led_xerr = 1'b1;

    // run through row 7, then drop enable mid-cycle
    wait_latch(8, 60000);
    step(4000);
    check("xerr_sticky", xerr_flag, 1);
    enable = 1'b0;
    wait_latch(9, 9000);
    step(20);
    check("drop_blank", led_blank, 1);
    check("drop_gsclk", led_gsclk, 0);
    step(400);
    check("drop_latches", xlat_cnt, 9);
    check("drop_idle", led_blank, 1);
    check("drop_row", row_sel, 0);
    check("frames_wrap", frame_cnt, 2);

    // restart, then reset at bit 100 of the shift
    exp_q.delete();
    first  = 1'b1;
    push_row(0);
    bit_no = 0;
    enable = 1'b1;
    k = 0;
    while (bit_no < 100 && k < 1000) begin
      step(1);
      k++;
    end
    check("bit100", bit_no, 100);
    reset_n = 1'b0;
    step(1);
    check_idle("midrst");
    step(1);
    exp_q.delete();
    first  = 1'b1;
    push_row(0);
    bit_no = 0;
    reset_n = 1'b1;
    step(50);
    enable = 1'b0;
    wait_latch(10, 1000);
    step(20);
    check("rst_latches", xlat_cnt, 10);
    check("rst_frames", frame_cnt, 3);
    check("rst_blank", led_blank, 1);
    check("rst_row", row_sel, 0);
    check("rst_xerr", xerr_flag, 0);
    check("sb_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tlc_scan_sequencer.md
# tlc_scan_sequencer

Sequences the left/right TLC5940 driver chains on the LED panel. It runs each grayscale PWM cycle on `led_gsclk` and meanwhile shifts the next row's 192-bit grayscale word into every lane from the frame buffer. At the end of each cycle it blanks, latches and advances the row. It sits between the frame-buffer read port and the `led_*` pins, replacing ad-hoc pin driving in `toplevel`.

## Interface
- `GS_BITS`, 12: grayscale bits per channel.
- `CHANNELS`, 16: channels per chain; shift length `SHIFT_LEN` = `GS_BITS`*`CHANNELS` = 192.
- `LANES`, 6: chains per side.
- `ROWS`, 8: multiplexed rows; power of two.
- `GS_COUNT`, 4096: `led_gsclk` rising edges per PWM cycle.

Ports:
- `clock` in 1: system clock, 40 MHz.
- `reset_n` in 1: synchronous, active-low reset.
- `enable` in 1: run request (level).
- `rd_addr` out log2(`ROWS`*`SHIFT_LEN`): frame-buffer address = row*`SHIFT_LEN`+bit_index.
- `rd_en` out 1: read strobe.
- `rd_data` in 2*`LANES`: one bit per lane, valid the cycle after `rd_en`; [`LANES`-1:0] left, upper half right.
- `led_sclk` out 1: serial shift clock.
- `led_l_sin` out `LANES` ([6:1] at default): left serial data.
- `led_r_sin` out `LANES`: right serial data.
- `led_xerr` in 1: open-drain error from the drivers, active-low, asynchronous.
- `led_mode` out 1: tied 0 (grayscale mode).
- `led_blank` out 1: driver blank.
- `led_xlat` out 1: driver latch.
- `led_gsclk` out 1: grayscale PWM clock.
- `row_sel` out log2(`ROWS`): active row for the row drivers.
- `frame_start` out 1: one-cycle pulse when `row_sel` becomes 0.
- `xerr_flag` out 1: sticky error, cleared only by reset.

## Operation
Reset values:
- `led_blank`=1.
- All other outputs 0.
- `row_sel`=0, shift row pointer=0, state IDLE.

Main FSM:
- IDLE: `led_blank`=1, `led_gsclk`=0. When `enable`=1, start a shift of row 0, then go to PRIME.
- PRIME: wait for shift done, then BLANK.
- GS_RUN: `led_blank`=0; `led_gsclk` toggles every cycle, 4096 rising edges = 8192 cycles. In parallel, shift row (`row_sel`+1) mod `ROWS`. On the last falling edge go to BLANK.
- BLANK: `led_blank`=1, one cycle. If the shift is not done, stay here. Otherwise go to LATCH.
- LATCH: `led_xlat`=1, one cycle. `row_sel` ← shift row, except on the first pass from PRIME, where it stays 0. Then go to UNBLANK.
- UNBLANK: `led_blank` still 1. If `enable`=0, go to IDLE; else start the next shift and go to GS_RUN.

Shift engine:
- Bit order: bit_index 0 = channel 15 MSB … bit_index 191 = channel 0 LSB.
- Each bit takes 2 cycles:
  - Phase A: `led_sclk`=0; sin ← registered `rd_data`.
  - Phase B: `led_sclk`=1.
- `rd_en` for bit i+1 is issued in phase A of bit i. Bit 0 is prefetched one cycle before the first phase A.
- Done after the phase B of bit 191; `led_sclk` then returns to 0.

xerr handling:
- `led_xerr` passes through a 2-flop synchronizer.
- It is sampled only in GS_RUN. A synchronized 0 there sets `xerr_flag`.

`enable` dropping mid-cycle does not truncate anything: the current GS_RUN and the latch complete, then the FSM goes to IDLE.

## Timing
- Shift takes 1 + 2*192 = 385 cycles, well inside the 8192-cycle GS_RUN, so BLANK normally lasts exactly 1 cycle.
- Row-to-row gap: BLANK, LATCH, UNBLANK = 3 cycles of `led_blank`=1. `led_xlat` rises and falls entirely inside it.
- `row_sel` changes on the same edge `led_xlat` deasserts.
- `frame_start` is asserted in the cycle `row_sel` becomes 0 via LATCH, including the first pass.
- Row period: 8192 + 3 = 8195 cycles.
- Wrap-around: `row_sel` `ROWS`-1 → 0; the row pointer is mod `ROWS`; bit_index 191 → 0.
- Reset mid-operation: on the next edge every output takes its reset value, including `led_blank`=1 and `led_xlat`=0; no partial latch.
- `led_sclk` and `led_gsclk` are registered outputs with no combinational path from inputs.

## Structure
- Shared package `tlc_pkg`:
  - FSM state enum (IDLE, PRIME, GS_RUN, BLANK, LATCH, UNBLANK).
  - `SHIFT_LEN`, `GS_COUNT`, and the address-width function.
- One sub-module `tlc_shift_engine`:
  - Inputs: start, row.
  - Outputs: done, `rd_addr`/`rd_en`, `led_sclk`, sin lanes.
- The top holds the FSM, the GS counter, the row pointer and the xerr synchronizer.

## Test plan
- Reset/idle: hold `reset_n`=0 for 4 cycles, then `enable`=0 for 100 cycles → `led_blank`=1, `led_xlat`=`led_sclk`=`led_gsclk`=0, `row_sel`=0, `led_mode`=0.
- Start-up: raise `enable`; frame-buffer model returns `rd_data`=addr[11:0] → 192 `led_sclk` rises. Then `led_xlat` pulses once with `row_sel`=0 and `frame_start`=1; lane 1 bit stream matches the model; `led_blank` falls 3 cycles after BLANK entry.
- PWM cycle: count `led_gsclk` rising edges while `led_blank`=0 → exactly 4096 per row; 8195 cycles between consecutive `led_xlat` rises.
- Row wrap: run 9 rows → `row_sel` goes 0,1,…,7,0; `frame_start` fires twice; shifted data address base = next row*192.
- Error: drive `led_xerr`=0 for 3 cycles during GS_RUN → `xerr_flag`=1 within 3 cycles and sticky. The same pulse during BLANK → no effect.
- `enable` drop / reset mid-shift: drop `enable` halfway through GS_RUN → cycle completes, one latch, then IDLE with `led_blank`=1. Separately, assert `reset_n`=0 at bit 100 → next cycle all reset values; a restart shifts row 0 from bit 0.
